axi_burst_master: RTL and testbench

//  AXI4 burst master that sits directly upstream of the AXI RAM slave and drives its axi_mosi_t/axi_miso_t port.

---
 rtl/axi_burst_master_pkg.sv | 56 +++++
 rtl/axi_burst_beat_ctr.sv | 29 ++
 rtl/axi_burst_master.sv | 152 +++++++++++++++
 tb/tb_axi_burst_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_master_pkg.sv
// axi_burst_master_pkg: shared states, AXI constants and channel bundles for the burst master.
package axi_burst_master_pkg;

    localparam int AXI_ID_W_W  = 4;
    localparam int AXI_ID_R_W  = 4;
    localparam int AXI_ADDR_W  = 16;
    localparam int AXI_DATA_W  = 32;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_e;

    typedef struct packed {
        logic [AXI_ID_W_W-1:0]   aw_id;
        logic [AXI_ADDR_W-1:0]   aw_addr;
        logic [7:0]              aw_len;
        logic [2:0]              aw_size;
        logic [1:0]              aw_burst;
        logic                    aw_valid;
        logic [AXI_DATA_W-1:0]   w_data;
        logic [AXI_DATA_W/8-1:0] w_strb;
        logic                    w_last;
        logic                    w_valid;
        logic                    b_ready;
        logic [AXI_ID_R_W-1:0]   ar_id;
        logic [AXI_ADDR_W-1:0]   ar_addr;
        logic [7:0]              ar_len;
        logic [2:0]              ar_size;
        logic [1:0]              ar_burst;
        logic                    ar_valid;
        logic                    r_ready;
    } axi_mosi_t;

    typedef struct packed {
        logic                    aw_ready;
        logic                    w_ready;
        logic [AXI_ID_W_W-1:0]   b_id;
        logic [1:0]              b_resp;
        logic                    b_valid;
        logic                    ar_ready;
        logic [AXI_ID_R_W-1:0]   r_id;
        logic [AXI_DATA_W-1:0]   r_data;
        logic [1:0]              r_resp;
        logic                    r_last;
        logic                    r_valid;
    } axi_miso_t;

    function automatic int clog2_bytes(input int width);
        int n;
        n = 0;
        while ((8 << n) < width) n++;
        return n;
    endfunction

endpackage

// File: rtl/axi_burst_beat_ctr.sv
// axi_burst_beat_ctr: beat index of the current burst, last-beat flag and the seed+index data pattern.
module axi_burst_beat_ctr #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [7:0]            len_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] pattern_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? 8'd0 : inc_i ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign last_o    = cnt_q == len_i;
    assign pattern_o = seed_i + DATA_WIDTH'(cnt_q);

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: one-command-at-a-time AXI4 INCR burst master that writes a seed+k pattern
// or reads a burst back and counts response/data errors.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int ID_W_WIDTH     = 4,
    parameter int ID_R_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ERR_W          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [ID_W_WIDTH-1:0]     cmd_id_i,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_seed_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ERR_W-1:0]          err_cnt_o,
    output axi_mosi_t                 out_mosi_o,
    input  axi_miso_t                 out_miso_i
);

    localparam int LSB = clog2_bytes(AXI_DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << LSB;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [ID_W_WIDTH-1:0]     id_q, id_d;
    logic [AXI_DATA_WIDTH-1:0] seed_q, seed_d;
    logic                      drain_q, drain_d;
    logic [ERR_W-1:0]          err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0] pattern;
    logic                      ctr_load, ctr_inc, last, err_inc, beat_err;

    axi_burst_beat_ctr #(.DATA_WIDTH(AXI_DATA_WIDTH)) u_ctr (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (ctr_load),
        .inc_i     (ctr_inc),
        .len_i     (len_q),
        .seed_i    (seed_q),
        .last_o    (last),
        .pattern_o (pattern)
    );

    // RLAST must coincide with the final beat; both early and missing RLAST count here
    assign beat_err = (out_miso_i.r_data != pattern) || (out_miso_i.r_resp != RESP_OKAY) ||
                      (out_miso_i.r_id != id_q[ID_R_WIDTH-1:0]) || (out_miso_i.r_last != last);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        id_d     = id_q;
        seed_d   = seed_q;
        drain_d  = drain_q;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        err_inc  = 1'b0;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                addr_d   = cmd_addr_i & ADDR_MASK;
                len_d    = cmd_len_i;
                id_d     = cmd_id_i;
                seed_d   = cmd_seed_i;
                drain_d  = 1'b0;
                ctr_load = 1'b1;
                state_d  = cmd_write_i ? AW : AR;
            end
            AW: if (out_miso_i.aw_ready) state_d = W;
            W: if (out_miso_i.w_ready) begin
                ctr_inc = 1'b1;
                if (last) state_d = B;
            end
            B: if (out_miso_i.b_valid) begin
                err_inc = (out_miso_i.b_resp != RESP_OKAY) || (out_miso_i.b_id != id_q);
                state_d = DONE;
            end
            AR: if (out_miso_i.ar_ready) state_d = R;
            R: if (out_miso_i.r_valid) begin
                err_inc = !drain_q && beat_err;
                if (out_miso_i.r_last) state_d = DONE;
                else if (last)         drain_d = 1'b1;
                else                   ctr_inc = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d = (err_inc && !(&err_q)) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            seed_q  <= '0;
            drain_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            seed_q  <= seed_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Every VALID is decoded from the registered state; payloads read zero while idle
    always_comb begin
        out_mosi_o          = '0;
        out_mosi_o.aw_valid = state_q == AW;
        out_mosi_o.w_valid  = state_q == W;
        out_mosi_o.b_ready  = state_q == B;
        out_mosi_o.ar_valid = state_q == AR;
        out_mosi_o.r_ready  = state_q == R;
        if (state_q == AW) begin
            out_mosi_o.aw_id    = id_q;
            out_mosi_o.aw_addr  = addr_q;
            out_mosi_o.aw_len   = len_q;
            out_mosi_o.aw_size  = 3'(LSB);
            out_mosi_o.aw_burst = BURST_INCR;
        end
        if (state_q == W) begin
            out_mosi_o.w_data = pattern;
            out_mosi_o.w_strb = '1;
            out_mosi_o.w_last = last;
        end
        if (state_q == AR) begin
            out_mosi_o.ar_id    = id_q[ID_R_WIDTH-1:0];
            out_mosi_o.ar_addr  = addr_q;
            out_mosi_o.ar_len   = len_q;
            out_mosi_o.ar_size  = 3'(LSB);
            out_mosi_o.ar_burst = BURST_INCR;
        end
    end

    assign cmd_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: RAM slave model with optional backpressure and fault injection,
// scoreboard of expected AW/AR/W traffic, and error/latency checks on the burst master.
module tb_axi_burst_master;
    import axi_burst_master_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_seed = '0;
    logic        cmd_ready_o, busy_o, done_o;
    logic [15:0] err_cnt_o;
    axi_mosi_t   mosi;
    axi_miso_t   miso;

    axi_burst_master dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id), .cmd_seed_i(cmd_seed),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .out_mosi_o(mosi), .out_miso_i(miso)
    );

    int n_chk = 0, n_err = 0, exp_err = 0, cyc = 0, acc = 0, w_hs = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: ready gates, one idle cycle before RDATA/BRESP
    logic [31:0] mem [0:16383];
    bit          bp = 0, inj_slverr = 0, inj_early = 0, inj_late = 0;
    logic        aw_g = 1'b1, w_g = 1'b1, ar_g = 1'b1, r_g = 1'b1;
    logic [1:0]  ws, rs;
    logic [13:0] wptr, rptr;
    logic [7:0]  wlen, wk, rlen, rk;
    logic [3:0]  wid, rid;

    always @(posedge clk) begin
        aw_g <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
        w_g  <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
        ar_g <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
        r_g  <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws <= '0; rs <= '0; wptr <= '0; rptr <= '0;
            wlen <= '0; wk <= '0; rlen <= '0; rk <= '0; wid <= '0; rid <= '0;
        end else begin
            case (ws)
                2'd0: if (mosi.aw_valid && miso.aw_ready) begin
                    wptr <= mosi.aw_addr[15:2]; wlen <= mosi.aw_len; wid <= mosi.aw_id; wk <= '0; ws <= 2'd1;
                end
                2'd1: if (mosi.w_valid && miso.w_ready) begin
                    mem[wptr] <= mosi.w_data; wptr <= wptr + 14'd1; wk <= wk + 8'd1;
                    if (wk == wlen) ws <= 2'd2;
                end
                2'd2: ws <= 2'd3;
                default: if (mosi.b_ready) ws <= 2'd0;
            endcase
            case (rs)
                2'd0: if (mosi.ar_valid && miso.ar_ready) begin
                    rptr <= mosi.ar_addr[15:2]; rlen <= mosi.ar_len; rid <= mosi.ar_id; rk <= '0; rs <= 2'd1;
                end
                2'd1: rs <= 2'd2;
                default: if (miso.r_valid && mosi.r_ready) begin
                    if (miso.r_last) rs <= 2'd0;
                    else             rk <= rk + 8'd1;
                end
            endcase
        end
    end

    always_comb begin
        miso          = '0;
        miso.aw_ready = aw_g && ws == 2'd0;
        miso.w_ready  = w_g && ws == 2'd1;
        miso.b_valid  = ws == 2'd3;
        miso.b_id     = wid;
        miso.b_resp   = inj_slverr ? 2'b10 : 2'b00;
        miso.ar_ready = ar_g && rs == 2'd0;
        miso.r_valid  = r_g && rs == 2'd2;
        miso.r_id     = rid;
        miso.r_data   = mem[rptr + 14'(rk)];
        miso.r_last   = inj_early ? rk == 8'd1 : inj_late ? rk == rlen + 8'd1 : rk == rlen;
    end

    // Channel monitor: hold-until-ready, AW/W exclusivity, scoreboard pops on handshakes
    logic [32:0] aw_q[$], ar_q[$], w_q[$];
    logic [33:0] aw_bus, ar_bus, aw_sv, ar_sv;
    logic [37:0] w_bus, w_sv;
    logic        aw_pend, w_pend, ar_pend;
    assign aw_bus = {mosi.aw_valid, mosi.aw_id, mosi.aw_addr, mosi.aw_len, mosi.aw_size, mosi.aw_burst};
    assign ar_bus = {mosi.ar_valid, mosi.ar_id, mosi.ar_addr, mosi.ar_len, mosi.ar_size, mosi.ar_burst};
    assign w_bus  = {mosi.w_valid, mosi.w_data, mosi.w_strb, mosi.w_last};

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (aw_pend) chk("aw_hold", 64'(aw_bus), 64'(aw_sv));
            if (w_pend)  chk("w_hold", 64'(w_bus), 64'(w_sv));
            if (ar_pend) chk("ar_hold", 64'(ar_bus), 64'(ar_sv));
            aw_pend <= mosi.aw_valid && !miso.aw_ready; aw_sv <= aw_bus;
            w_pend  <= mosi.w_valid && !miso.w_ready;   w_sv  <= w_bus;
            ar_pend <= mosi.ar_valid && !miso.ar_ready; ar_sv <= ar_bus;
            if (mosi.aw_valid || mosi.w_valid)
                chk("aw_w_overlap", 64'(mosi.aw_valid && mosi.w_valid), 64'(0));
            if (mosi.aw_valid && miso.aw_ready) begin
                chk("aw_expected", 64'(aw_q.size() != 0), 64'(1));
                if (aw_q.size() != 0) begin
                    chk("aw_fields", 64'(aw_bus[32:0]), 64'(aw_q[0]));
                    void'(aw_q.pop_front());
                end
            end
            if (mosi.ar_valid && miso.ar_ready) begin
                chk("ar_expected", 64'(ar_q.size() != 0), 64'(1));
                if (ar_q.size() != 0) begin
                    chk("ar_fields", 64'(ar_bus[32:0]), 64'(ar_q[0]));
                    void'(ar_q.pop_front());
                end
            end
            if (mosi.w_valid && miso.w_ready) begin
                chk("w_expected", 64'(w_q.size() != 0), 64'(1));
                if (w_q.size() != 0) begin
                    chk("w_data", 64'(mosi.w_data), 64'(w_q[0][32:1]));
                    chk("w_last", 64'(mosi.w_last), 64'(w_q[0][0]));
                    chk("w_strb", 64'(mosi.w_strb), 64'(4'hF));
                    void'(w_q.pop_front());
                end
                w_hs <= w_hs + 1;
            end
        end
    end

    task automatic push_exp(input bit wr, input logic [15:0] a, input logic [7:0] l,
                            input logic [3:0] id, input logic [31:0] s);
        if (wr) begin
            aw_q.push_back({id, a & 16'hFFFC, l, 3'd2, 2'b01});
            for (int k = 0; k <= int'(l); k++) w_q.push_back({s + 32'(k), k == int'(l)});
        end else begin
            ar_q.push_back({id, a & 16'hFFFC, l, 3'd2, 2'b01});
        end
    endtask

    task automatic send(input bit wr, input logic [15:0] a, input logic [7:0] l,
                        input logic [3:0] id, input logic [31:0] s);
        int t = 0;
        @(negedge clk);
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_seed = s; cmd_valid = 1'b1;
        while (!cmd_ready_o && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", 64'(cmd_ready_o), 64'(1));
        push_exp(wr, a, l, id, s);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int exp_lat);
        int t = 0;
        @(negedge clk);
        while (!done_o && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 64'(done_o), 64'(1));
        chk("busy_at_done", 64'(busy_o), 64'(1));
        if (exp_lat >= 0) chk("latency", 64'(cyc - acc + 1), 64'(exp_lat));
        @(negedge clk);
        chk("done_pulse", 64'(done_o), 64'(0));
        chk("idle_ready", 64'(cmd_ready_o), 64'(1));
        chk("err_cnt", 64'(err_cnt_o), 64'(exp_err));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'(1));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
        chk({tag, "_err"}, 64'(err_cnt_o), 64'(0));
        chk({tag, "_mosi_zero"}, 64'(mosi == '0), 64'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  l;
        logic [3:0]  id;
        logic [31:0] s;
        int base, t;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        send(1, 16'h0010, 8'd3, 4'h3, 32'hA000); wait_done(8);
        send(0, 16'h0010, 8'd3, 4'h3, 32'hA000); wait_done(7);
        exp_err += 4;
        send(0, 16'h0010, 8'd3, 4'h3, 32'hA001); wait_done(7);

        inj_slverr = 1; exp_err += 1;
        send(1, 16'h0100, 8'd1, 4'h5, 32'h0000_0055); wait_done(6);
        inj_slverr = 0; inj_early = 1; exp_err += 1;
        send(0, 16'h0010, 8'd3, 4'h3, 32'hA000); wait_done(-1);
        inj_early = 0; inj_late = 1; exp_err += 1;
        send(0, 16'h0010, 8'd3, 4'h3, 32'hA000); wait_done(-1);
        inj_late = 0;

        send(1, 16'h0203, 8'd0, 4'hC, 32'hFFFF_FFFF); wait_done(5);
        send(0, 16'h0202, 8'd0, 4'hC, 32'hFFFF_FFFF); wait_done(4);
        send(1, 16'h0300, 8'd3, 4'h9, 32'hFFFF_FFFE); wait_done(8);
        send(0, 16'h0300, 8'd3, 4'h9, 32'hFFFF_FFFE); wait_done(7);

        send(1, 16'h0400, 8'd2, 4'h1, 32'h1234_0000);
        cmd_write = 1'b0; cmd_addr = 16'h0400; cmd_len = 8'd2; cmd_id = 4'h2; cmd_seed = 32'h1234_0000;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("held_off", 64'(cmd_ready_o), 64'(0));
        wait_done(-1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        acc = cyc;
        push_exp(0, 16'h0400, 8'd2, 4'h2, 32'h1234_0000);
        wait_done(6);

        bp = 1;
        for (int i = 0; i < 500; i++) begin
            a  = 16'($urandom);
            l  = 8'($urandom_range(0, 7));
            id = 4'($urandom);
            s  = $urandom;
            send(1, a, l, id, s); wait_done(-1);
            send(0, a, l, id, s); wait_done(-1);
        end
        bp = 0;

        send(1, 16'h0800, 8'd7, 4'h6, 32'h0BAD_0000);
        base = w_hs;
        t = 0;
        while (!(w_hs == base + 2 && mosi.w_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("w_beat2_reached", 64'(w_hs == base + 2 && mosi.w_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_valids", 64'({mosi.aw_valid, mosi.w_valid, mosi.ar_valid, mosi.b_ready, mosi.r_ready}), 64'(0));
        check_reset_state("midburst_reset");
        aw_q.delete(); ar_q.delete(); w_q.delete();
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1, 16'h0900, 8'd4, 4'h7, 32'h0000_7000); wait_done(9);
        send(0, 16'h0900, 8'd4, 4'h7, 32'h0000_7000); wait_done(8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
